// File: rtl/conv_window_gen_3x3.sv
// conv_window_gen_3x3: turns a raster-order 8-bit pixel stream into packed
// 3x3 windows for the convolution stage. Two line buffers hold the previous
// two rows, and a 3-column shift register holds the window. Only windows that
// lie fully inside the frame are emitted.
// pixels_out byte k = 3*row + col (row 0 = top line, col 0 = leftmost).
// A single output register acts as a skid stage, so the block moves one pixel
// per cycle while out_ready stays high.
// Optional: define CONV_WIN_EOF_EN to add out_last, which flags the final
// window of each frame.
module conv_window_gen_3x3 #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  pixel_in,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef CONV_WIN_EOF_EN
  output logic        out_last,
`endif
  output logic [71:0] pixels_out
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             out_valid_q, out_valid_d;
  // Each window column packs {top, mid, bottom}; index 0 is the leftmost column.
  logic [2:0][23:0] win_q, win_d;

  logic [7:0] lb0_mem [IMG_WIDTH];  // row r-1
  logic [7:0] lb1_mem [IMG_WIDTH];  // row r-2

  logic       accept;
  logic       win_done;
  logic [7:0] top_tap;
  logic [7:0] mid_tap;

  assign in_ready  = rst_n && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign top_tap   = lb1_mem[col_q];
  assign mid_tap   = lb0_mem[col_q];
  assign win_done  = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign out_valid = out_valid_q;

  // Next-state: advance the counters and shift the window on accept, and
  // drop out_valid once a window is consumed and nothing replaces it.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave a latch.
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      win_d[0]    = win_q[1];
      win_d[1]    = win_q[2];
      win_d[2]    = {top_tap, mid_tap, pixel_in};
      out_valid_d = win_done;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge.
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Line buffers: push the column down one row on each accepted pixel.
  always_ff @(posedge clk) begin
    // NOTE: the RAMs are deliberately not reset. The row/col gating ensures
    // stale contents never reach an emitted window.
    if (accept) begin
      lb1_mem[col_q] <= lb0_mem[col_q];
      lb0_mem[col_q] <= pixel_in;
    end
  end

  // Unpack the window columns into the row-major byte layout used downstream.
  always_comb begin
    pixels_out = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        pixels_out[8*(3*r+c) +: 8] = win_q[c][8*(2-r) +: 8];
      end
    end
  end

`ifdef CONV_WIN_EOF_EN
  logic out_last_q, out_last_d;

  assign out_last = out_last_q;

  // End-of-frame flag: set by the last pixel of the frame, held with the window.
  always_comb begin
    out_last_d = out_last_q;
    if (accept) begin
      out_last_d = win_done && (row_q == ROW_LAST) && (col_q == COL_LAST);
    end else if (out_ready) begin
      out_last_d = 1'b0;
    end
  end

  // End-of-frame flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) out_last_q <= 1'b0;
    else        out_last_q <= out_last_d;
  end
`else
  // Without the end-of-frame option there is no out_last port and no extra state.
`endif

endmodule

// File: doc/conv_window_gen_3x3.md
Name: conv_window_gen_3x3

Overview:
- Upstream feeder for the 3x3 8-channel convolution datapath.
- Accepts a raster-order 8-bit pixel stream, one pixel per handshake.
- Buffers two image lines and emits each fully-populated 3x3 window as a packed 72-bit word whose layout matches the convolution stage's 72-bit pixel input.
- No padding: only windows lying entirely inside the frame are produced.

Parameters:
- IMG_WIDTH, 16, pixels per line; legal range 3..1024.
- IMG_HEIGHT, 16, lines per frame; legal range 3..1024.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  pixel_in valid.
- in_ready  output  1  block can accept a pixel this cycle.
- pixel_in  input  8  unsigned pixel, raster order, first pixel of a frame at (row 0, col 0).
- out_valid  output  1  pixels_out holds a valid window.
- out_ready  input  1  downstream accepts the window.
- pixels_out  output  72  packed window; byte k = bits [8k+7:8k], k = 3*row + col; row 0 = oldest (top) line, col 0 = leftmost.

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, pixels_out=0, row/col counters=0, window registers=0. in_ready is forced 0 while rst_n is low. Line-buffer RAM is not reset; stale contents are never exposed, because windows are gated by counters.
- Input accept: the block accepts a pixel when in_valid && in_ready. in_ready = !out_valid || out_ready, giving a single-entry output skid with full throughput (one pixel per cycle with out_ready held high).
- Counters: col counts 0..IMG_WIDTH-1. At wrap, col returns to 0 and row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), both return to 0, and the next pixel starts a new frame with no idle cycle required.
- Line buffers: two IMG_WIDTH x 8 arrays, LB1 holding row r-2 and LB0 holding row r-1. On accept of pixel p at column c:
  - top tap = LB1[c], mid tap = LB0[c], bottom tap = p.
  - LB1[c] <= LB0[c]; LB0[c] <= p.
- Window register: 3x3 shift. On each accept, columns shift left (col0 <= col1, col1 <= col2) and col2 <= {top, mid, bottom}.
- Output:
  - When the accepted pixel has row >= 2 and col >= 2, the next cycle has out_valid=1 and pixels_out = the 3x3 neighbourhood ending at that pixel. Latency is 1 cycle from accept to out_valid.
  - When the accepted pixel does not satisfy row >= 2 and col >= 2, out_valid clears if the current window was consumed.
  - Windows spanning a line wrap (col < 2) are never emitted.
- Hold: while out_valid && !out_ready, pixels_out and out_valid stay stable, in_ready=0, and no state advances.
- Simultaneous out_ready and in_valid: the current window is consumed and the new pixel is accepted in the same cycle; if it completes a window, that window is presented next cycle.
- Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame. The first window appears only after 2*IMG_WIDTH+3 further accepts.
- Arithmetic: pure data movement, no arithmetic. Counter widths are $clog2 of each parameter.

Optional Feature:
- Macro CONV_WIN_EOF_EN.
- When defined: adds output out_last (1 bit, reset 0), asserted together with out_valid for the final window of each frame (centre pixel at row IMG_HEIGHT-2, col IMG_WIDTH-2, i.e. accept at the last pixel of the frame). out_last follows the same hold rules as pixels_out.
- When undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4 and pixel value = 4*row+col unless noted.
- First window: stream pixels 0..15 with out_ready=1 -> first out_valid one cycle after accepting pixel 10; pixels_out = 72'h0A_09_08_06_05_04_02_01_00.
- Frame window count and order: full frame -> exactly 4 windows, with centre bytes (byte4) 0x05, 0x06, 0x09, 0x0A in order. No window is emitted on pixels 0..9, 12, or 13.
- Backpressure: hold out_ready=0 after the first window -> in_ready=0, pixels_out stays 72'h0A_09_08_06_05_04_02_01_00. Release -> next window has byte4=0x06 and there is no data loss or duplicate.
- Back-to-back frames: two frames, the second with pixel = 0x80+index, in_valid continuously high -> 8 windows total. The first window of frame 2 = 72'h8A_89_88_86_85_84_82_81_80, with no frame-1 data in it.
- Reset mid-frame: assert rst_n=0 for 1 cycle after pixel 7 -> out_valid=0 that cycle. Then restart the frame from 0 -> output identical to the first-window scenario.
- CONV_WIN_EOF_EN build: full frame -> out_last=1 only on the 4th window (byte4=0x0A), and 0 on all others.
